// File: rtl/block_deinterleaver.sv
// Block deinterleaver: buffers one line-major interleaved codeword and replays it column-major
// (line index fastest), supporting a partially filled last column for shortened codewords.
module block_deinterleaver #(
    parameter int NUMBER_OF_ELEMENTS = 12,
    parameter int NUMBER_OF_LINES    = 3,
    parameter int WORD_LENGTH        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic                   i_start_cw,
    input  logic                   i_end_cw,
    input  logic [WORD_LENGTH-1:0] i_data,
    input  logic                   i_consume,
    output logic                   o_in_ready,
    output logic                   o_valid,
    output logic                   o_start_cw,
    output logic                   o_end_cw,
    output logic                   o_error,
    output logic [WORD_LENGTH-1:0] o_data
);

    localparam int CW   = $clog2(NUMBER_OF_ELEMENTS + 1);
    localparam int AW   = (NUMBER_OF_ELEMENTS > 1) ? $clog2(NUMBER_OF_ELEMENTS) : 1;
    localparam int LW   = (NUMBER_OF_LINES > 1) ? $clog2(NUMBER_OF_LINES) : 1;
    localparam int NCOL = (NUMBER_OF_ELEMENTS + NUMBER_OF_LINES - 1) / NUMBER_OF_LINES;
    localparam int COLW = (NCOL > 1) ? $clog2(NCOL) : 1;

    localparam logic [2:0] StIdle         = 3'd0;
    localparam logic [2:0] StReceiving    = 3'd1;
    localparam logic [2:0] StTransmitting = 3'd2;
    localparam logic [2:0] StError        = 3'd3;
    localparam logic [2:0] StPrefetch     = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]          addr_q, addr_d, n_q, n_d;
    logic [LW-1:0]          lin_q, lin_d, last_lin_q, last_lin_d;
    logic [COLW-1:0]        col_q, col_d, last_col_q, last_col_d;
    logic [WORD_LENGTH-1:0] mem [NUMBER_OF_ELEMENTS];
    logic [WORD_LENGTH-1:0] data_q;
    logic                   accept, last_word, wr_en, rd_en, clear;
    logic [CW-1:0]          rd_addr, row_len;

    assign o_in_ready = (state_q == StIdle) || (state_q == StReceiving);
    assign accept     = i_valid && o_in_ready;
    assign o_valid    = (state_q == StTransmitting);
    assign last_word  = (rd_cnt_q == n_q - 1'b1);
    assign o_start_cw = o_valid && (rd_cnt_q == '0);
    assign o_end_cw   = o_valid && last_word;
    assign o_error    = (state_q == StError);
    assign o_data     = data_q;

    // Lines up to last_lin hold a word in the partially filled last column.
    assign row_len = (lin_q <= last_lin_q) ? CW'(last_col_q) + 1'b1 : CW'(last_col_q);

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        addr_d     = addr_q;
        n_d        = n_q;
        lin_d      = lin_q;
        col_d      = col_q;
        last_lin_d = last_lin_q;
        last_col_d = last_col_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = addr_q;
        clear      = 1'b0;
        case (state_q)
            StIdle, StReceiving: begin
                if (accept) begin
                    // Start is mandatory in IDLE and forbidden mid-codeword.
                    if (((state_q == StIdle) != i_start_cw) ||
                        (wr_cnt_q == CW'(NUMBER_OF_ELEMENTS))) begin
                        state_d = StError;
                    end else begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        state_d  = StReceiving;
                        if (i_end_cw) begin
                            n_d        = wr_cnt_q + 1'b1;
                            last_lin_d = LW'(wr_cnt_q % CW'(NUMBER_OF_LINES));
                            last_col_d = COLW'(wr_cnt_q / CW'(NUMBER_OF_LINES));
                            state_d    = StPrefetch;
                        end
                    end
                end
            end
            StPrefetch: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                addr_d   = '0;
                lin_d    = '0;
                col_d    = '0;
                rd_cnt_d = '0;
                state_d  = StTransmitting;
            end
            StTransmitting: begin
                if (i_consume) begin
                    if (last_word) begin
                        clear   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (lin_q == LW'(NUMBER_OF_LINES - 1)) begin
                            lin_d  = '0;
                            col_d  = col_q + 1'b1;
                            addr_d = CW'(col_q) + 1'b1;
                        end else begin
                            lin_d  = lin_q + 1'b1;
                            addr_d = addr_q + row_len;
                        end
                        rd_en   = 1'b1;
                        rd_addr = addr_d;
                    end
                end
            end
            StError: begin
                clear   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (clear) begin
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            addr_d     = '0;
            n_d        = '0;
            lin_d      = '0;
            col_d      = '0;
            last_lin_d = '0;
            last_col_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            addr_q     <= '0;
            n_q        <= '0;
            lin_q      <= '0;
            col_q      <= '0;
            last_lin_q <= '0;
            last_col_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            lin_q      <= lin_d;
            col_q      <= col_d;
            last_lin_q <= last_lin_d;
            last_col_q <= last_col_d;
            if (rd_en) begin
                data_q <= mem[AW'(rd_addr)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[AW'(wr_cnt_q)] <= i_data;
        end
    end

endmodule

// File: tb/tb_block_deinterleaver.sv
// Directed bench for block_deinterleaver: a reference interleaver builds each input stream and
// the original words go to a scoreboard queue that is popped as the DUT output is consumed.
module tb_block_deinterleaver;

    localparam int NE = 12;
    localparam int L  = 3;
    localparam int W  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0, i_start_cw = 1'b0, i_end_cw = 1'b0, i_consume = 1'b0;
    logic [W-1:0] i_data = '0;
    logic         o_in_ready, o_valid, o_start_cw, o_end_cw, o_error;
    logic [W-1:0] o_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic         s;
        logic         e;
        logic [W-1:0] d;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] stim_q[$];

    block_deinterleaver #(
        .NUMBER_OF_ELEMENTS(NE),
        .NUMBER_OF_LINES   (L),
        .WORD_LENGTH       (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_start_cw(i_start_cw),
        .i_end_cw  (i_end_cw),
        .i_data    (i_data),
        .i_consume (i_consume),
        .o_in_ready(o_in_ready),
        .o_valid   (o_valid),
        .o_start_cw(o_start_cw),
        .o_end_cw  (o_end_cw),
        .o_error   (o_error),
        .o_data    (o_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference interleaver: original word k lands at lin*(C-1)+min(lin,last_lin+1)+col.
    task automatic build(input int n, input int base);
        logic [W-1:0] buf_m [NE];
        int c, ll, lin, col, a;
        c  = (n + L - 1) / L;
        ll = (n - 1) % L;
        stim_q.delete();
        for (int k = 0; k < n; k++) begin
            lin = k % L;
            col = k / L;
            a   = lin * (c - 1) + ((lin < ll + 1) ? lin : ll + 1) + col;
            buf_m[a] = W'(base + k);
            exp_q.push_back('{s: (k == 0), e: (k == n - 1), d: W'(base + k)});
        end
        for (int i = 0; i < n; i++) stim_q.push_back(buf_m[i]);
    endtask

    task automatic send(input bit consume_early);
        int n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ready_in", 16'(o_in_ready), 16'd1);
            i_valid    = 1'b1;
            i_start_cw = (i == 0);
            i_end_cw   = (i == n - 1);
            i_data     = stim_q[i];
            i_consume  = consume_early;
        end
        @(negedge clk);
        i_valid    = 1'b0;
        i_start_cw = 1'b0;
        i_end_cw   = 1'b0;
        check("prefetch", 16'({o_valid, o_in_ready}), 16'b00);
    endtask

    // mode 0: consume every cycle; mode 1: consume pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int max_words, input bit junk);
        int   j, popped;
        exp_t e;
        j      = 0;
        popped = 0;
        while (exp_q.size() > 0 && popped < max_words) begin
            @(negedge clk);
            e = exp_q[0];
            check("out_word", 16'({o_valid, o_start_cw, o_end_cw, o_error, o_data}),
                  16'({1'b1, e.s, e.e, 1'b0, e.d}));
            i_valid    = junk;
            i_start_cw = junk;
            i_data     = W'(j);
            i_consume  = (mode == 0) || (j % 3 == 0);
            if (i_consume) begin
                void'(exp_q.pop_front());
                popped++;
            end
            j++;
        end
        if (exp_q.size() == 0) begin
            @(negedge clk);
            i_consume  = 1'b0;
            i_valid    = 1'b0;
            i_start_cw = 1'b0;
            check("ready_back", 16'({o_valid, o_in_ready, o_error}), 16'b010);
        end
    endtask

    task automatic drive_word(input logic s, input logic e, input logic [W-1:0] d);
        @(negedge clk);
        check("no_err", 16'(o_error), 16'd0);
        i_valid    = 1'b1;
        i_start_cw = s;
        i_end_cw   = e;
        i_data     = d;
    endtask

    task automatic expect_error(input string tag);
        @(negedge clk);
        i_valid    = 1'b0;
        i_start_cw = 1'b0;
        i_end_cw   = 1'b0;
        check(tag, 16'({o_error, o_in_ready, o_valid}), 16'b100);
        @(negedge clk);
        check({tag, "_after"}, 16'({o_error, o_in_ready, o_valid}), 16'b010);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", 16'({o_in_ready, o_valid, o_start_cw, o_end_cw, o_error, o_data}),
              16'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));
        rst = 1'b0;

        build(12, 0); send(1'b0); drain(0, 99, 1'b0);   // full codeword
        build(7, 0);  send(1'b1); drain(0, 99, 1'b0);   // shortened, early consume ignored
        build(1, 5);  send(1'b0); drain(0, 99, 1'b0);   // single word
        build(10, 2); send(1'b0); drain(1, 99, 1'b1);   // backpressure, ignored input

        drive_word(1'b0, 1'b0, 3'd3);
        expect_error("err_nostart");
        drive_word(1'b1, 1'b0, 3'd1);
        drive_word(1'b0, 1'b0, 3'd2);
        drive_word(1'b1, 1'b0, 3'd3);
        expect_error("err_restart");
        for (int i = 0; i < 13; i++) drive_word(i == 0, 1'b0, W'(i));
        expect_error("err_overflow");
        build(8, 3); send(1'b0); drain(0, 99, 1'b0);

        build(12, 1); send(1'b0); drain(0, 3, 1'b0);
        @(negedge clk);
        i_consume = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_mid", 16'({o_valid, o_in_ready, o_start_cw, o_end_cw, o_error}), 16'b01000);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_quiet", 16'({o_valid, o_in_ready}), 16'b01);
        build(5, 4); send(1'b0); drain(0, 99, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
